// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module  : alu_result_stage
//  Purpose : Registered valid/ready output stage behind the 16:1 ALU result
//            mux, with a 2-entry skid buffer, status flags and a result counter.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_Z,
    input  logic [3:0]             in_S,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_Z,
    output logic [3:0]             out_S,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic                   out_parity,
    output logic [COUNT_WIDTH-1:0] result_count
);

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [3:0]       s;
        logic             zero;
        logic             neg;
        logic             parity;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam entry_t RESET_ENTRY = '{z: '0, s: '0, zero: 1'b1, neg: 1'b0, parity: 1'b0};

    state_t                 state;
    state_t                 state_nxt;
    entry_t                 main_q;
    entry_t                 skid_q;
    entry_t                 in_entry;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   in_hs;
    logic                   out_hs;
    logic                   load_main_in;
    logic                   load_main_skid;
    logic                   load_skid;

    // Flags are computed before capture so out_* come straight from flops.
    always_comb begin
        in_entry.z      = in_Z;
        in_entry.s      = in_S;
        in_entry.zero   = (in_Z == '0);
        in_entry.neg    = in_Z[WIDTH-1];
        in_entry.parity = ^in_Z;
    end

    // Both handshake qualifiers are decoded from the state register only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    load_main_in = 1'b1;
                    state_nxt    = ONE;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_main_in = 1'b1;
                end else if (in_hs) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_hs) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_hs) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            main_q  <= RESET_ENTRY;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
            if (out_hs) begin
                count_q <= count_q + COUNT_WIDTH'(1);
            end
        end
    end

    assign out_Z        = main_q.z;
    assign out_S        = main_q.s;
    assign out_zero     = main_q.zero;
    assign out_neg      = main_q.neg;
    assign out_parity   = main_q.parity;
    assign result_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_result_stage
//  Purpose : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a queue-based reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu_result_stage;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rstb;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_Z;
    logic [3:0]    in_S;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_Z;
    logic [3:0]    out_S;
    logic          out_zero;
    logic          out_neg;
    logic          out_parity;
    logic [CW-1:0] result_count;

    int checks = 0;
    int errors = 0;

    alu_result_stage #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_Z         (in_Z),
        .in_S         (in_S),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_Z        (out_Z),
        .out_S        (out_S),
        .out_zero     (out_zero),
        .out_neg      (out_neg),
        .out_parity   (out_parity),
        .result_count (result_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [W-1:0]  z;
        logic [3:0]    s;
        logic          ordy;
        logic          e_ov;
        logic          e_ir;
        logic [W-1:0]  e_z;
        logic [3:0]    e_s;
        logic          e_zero;
        logic          e_neg;
        logic          e_par;
        logic [CW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic iv, input logic [W-1:0] z, input logic [3:0] s,
                                input logic ordy, input logic e_ov, input logic e_ir,
                                input logic [W-1:0] e_z, input logic [3:0] e_s,
                                input logic e_zero, input logic e_neg, input logic e_par,
                                input logic [CW-1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.z = z; v.s = s; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_z = e_z; v.e_s = e_s;
        v.e_zero = e_zero; v.e_neg = e_neg; v.e_par = e_par; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ir,
                           input logic [W-1:0] z, input logic [3:0] s, input logic zf,
                           input logic nf, input logic pf, input logic [CW-1:0] cnt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
        chk({tag, ".out_Z"}, 32'(out_Z), 32'(z));
        chk({tag, ".out_S"}, 32'(out_S), 32'(s));
        chk({tag, ".out_zero"}, 32'(out_zero), 32'(zf));
        chk({tag, ".out_neg"}, 32'(out_neg), 32'(nf));
        chk({tag, ".out_parity"}, 32'(out_parity), 32'(pf));
        chk({tag, ".result_count"}, 32'(result_count), 32'(cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_Z      = '0;
        in_S      = '0;
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        #1;
    endtask

    // Reference model: a FIFO of at most two {S,Z} results plus the last delivered one.
    logic [11:0]   mq[$];
    logic [W-1:0]  m_last_z;
    logic [3:0]    m_last_s;
    int            m_cnt;

    task automatic model_reset();
        mq.delete();
        m_last_z = '0;
        m_last_s = '0;
        m_cnt    = 0;
    endtask

    task automatic model_compare(input string tag);
        logic [W-1:0] ez;
        logic [3:0]   es;
        logic [11:0]  head;
        if (mq.size() > 0) begin
            head = mq[0];
            ez   = head[7:0];
            es   = head[11:8];
        end else begin
            ez = m_last_z;
            es = m_last_s;
        end
        chk_all(tag, mq.size() > 0, mq.size() < 2, ez, es, ez == 0, ez > 127,
                ($countones(ez) % 2) == 1, CW'(m_cnt % 16));
    endtask

    task automatic rand_cycle();
        logic        ihs;
        logic        ohs;
        logic [11:0] popped;
        in_valid  = 1'($urandom % 2);
        out_ready = ($urandom % 3) != 0;
        in_Z      = W'($urandom);
        in_S      = 4'($urandom);
        ihs = in_valid && (mq.size() < 2);
        ohs = out_ready && (mq.size() > 0);
        tick();
        if (ohs) begin
            popped   = mq.pop_front();
            m_last_z = popped[7:0];
            m_last_s = popped[11:8];
            m_cnt    = m_cnt + 1;
        end
        if (ihs) mq.push_back({in_S, in_Z});
        model_compare("rand");
    endtask

    initial begin
        rstb      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_Z      = '0;
        in_S      = '0;

        // iv, z, s, ordy -> ov, ir, z, s, zero, neg, parity, count
        vecs[0]  = mk(1, 8'h00, 4'h3, 1, 1, 1, 8'h00, 4'h3, 1, 0, 0, 4'd0);
        vecs[1]  = mk(0, 8'h00, 4'h0, 1, 0, 1, 8'h00, 4'h3, 1, 0, 0, 4'd1);
        vecs[2]  = mk(1, 8'h81, 4'h1, 0, 1, 1, 8'h81, 4'h1, 0, 1, 0, 4'd1);
        vecs[3]  = mk(1, 8'h07, 4'h2, 0, 1, 0, 8'h81, 4'h1, 0, 1, 0, 4'd1);
        vecs[4]  = mk(1, 8'hFF, 4'h4, 0, 1, 0, 8'h81, 4'h1, 0, 1, 0, 4'd1);
        vecs[5]  = mk(1, 8'hFF, 4'h4, 1, 1, 1, 8'h07, 4'h2, 0, 0, 1, 4'd2);
        vecs[6]  = mk(1, 8'hFF, 4'h4, 0, 1, 0, 8'h07, 4'h2, 0, 0, 1, 4'd2);
        vecs[7]  = mk(0, 8'h00, 4'h0, 1, 1, 1, 8'hFF, 4'h4, 0, 1, 0, 4'd3);
        vecs[8]  = mk(0, 8'h00, 4'h0, 1, 0, 1, 8'hFF, 4'h4, 0, 1, 0, 4'd4);
        vecs[9]  = mk(1, 8'h10, 4'h5, 0, 1, 1, 8'h10, 4'h5, 0, 0, 1, 4'd4);
        vecs[10] = mk(1, 8'h20, 4'h6, 1, 1, 1, 8'h20, 4'h6, 0, 0, 1, 4'd5);
        vecs[11] = mk(0, 8'h00, 4'h0, 1, 0, 1, 8'h20, 4'h6, 0, 0, 1, 4'd6);

        #12;
        chk_all("reset", 0, 1, 8'h00, 4'h0, 1, 0, 0, 4'd0);
        do_reset();
        chk_all("reset2", 0, 1, 8'h00, 4'h0, 1, 0, 0, 4'd0);

        for (int i = 0; i < 12; i++) begin
            in_valid  = vecs[i].iv;
            in_Z      = vecs[i].z;
            in_S      = vecs[i].s;
            out_ready = vecs[i].ordy;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_z,
                    vecs[i].e_s, vecs[i].e_zero, vecs[i].e_neg, vecs[i].e_par, vecs[i].e_cnt);
        end

        // Streaming 0..19 with the counter wrapping through 15 -> 0 -> 1.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_Z     = W'(i);
            in_S     = 4'(i);
            tick();
            chk($sformatf("stream%0d.out_Z", i), 32'(out_Z), 32'(i));
            chk($sformatf("stream%0d.out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d.count", i), 32'(result_count), 32'((6 + i) % 16));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end.out_valid", 32'(out_valid), 32'd0);
        chk("stream_end.count", 32'(result_count), 32'(26 % 16));

        // Fill to FULL, then reset asynchronously between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_Z = 8'hA1; in_S = 4'h8;
        tick();
        in_Z = 8'hA2; in_S = 4'h9;
        tick();
        in_valid = 1'b0;
        chk("full.in_ready", 32'(in_ready), 32'd0);
        #2;
        rstb = 1'b0;
        #1;
        chk_all("async_rst", 0, 1, 8'h00, 4'h0, 1, 0, 0, 4'd0);
        @(negedge clk);
        rstb = 1'b1;
        in_valid = 1'b1;
        in_Z = 8'h5A; in_S = 4'h7;
        tick();
        chk_all("post_rst", 1, 1, 8'h5A, 4'h7, 0, 0, 0, 4'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_all("post_rst_drain", 0, 1, 8'h5A, 4'h7, 0, 0, 0, 4'd1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        model_compare("rand_start");
        for (int i = 0; i < 400; i++) rand_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
